mem_arbiter: RTL and testbench

Two-port arbiter and sequencer that shares one synchronous single-port memory between the core's instruction-fetch path and its load/store unit. It sits between the core datapath and the memory macro, and serialises requests with round-robin fairness. It drives the memory command and counts the fixed read latency, then returns data and a completion strobe to the winning requester. It also supports flushing an in-flight fetch on a branch redirect.

---
 rtl/mem_arb_pkg.sv | 7 +
 rtl/rr_arb2.sv | 14 +
 rtl/mem_arbiter.sv | 114 +++++++++++
 tb/tb_mem_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the instruction/load-store memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} arb_state_t;
    typedef enum logic {REQ_IF, REQ_LS} req_id_t;
    localparam int MEM_LAT_MAX = 3;
    localparam int WORD = 32;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin picker; a tie goes to the requester not granted last
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic       if_req,
    input  logic       ls_req,
    input  req_id_t    last_gnt,
    output logic [1:0] gnt
);
    always_comb begin
        gnt[0] = if_req && (!ls_req || last_gnt == REQ_LS);
        gnt[1] = ls_req && (!if_req || last_gnt == REQ_IF);
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between fetch and load/store, one transaction at a time
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int MEM_LAT = 1
)(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    input  logic              i_if_flush,
    output logic              o_if_gnt,
    output logic              o_if_rvalid,
    output logic [WORD-1:0]   o_if_rdata,
    input  logic              i_ls_req,
    input  logic [ADDR_W-1:0] i_ls_addr,
    input  logic              i_ls_wren,
    input  logic [WORD-1:0]   i_ls_wdata,
    input  logic [3:0]        i_ls_bmask,
    output logic              o_ls_gnt,
    output logic              o_ls_rvalid,
    output logic [WORD-1:0]   o_ls_rdata,
    output logic              o_mem_en,
    output logic              o_mem_we,
    output logic [ADDR_W-3:0] o_mem_addr,
    output logic [WORD-1:0]   o_mem_wdata,
    output logic [3:0]        o_mem_bmask,
    input  logic [WORD-1:0]   i_mem_rdata,
    output logic              o_busy
);
    localparam int CW = $clog2(MEM_LAT_MAX + 1);

    arb_state_t        state, state_nx;
    req_id_t           last_gnt, id_q;
    logic [ADDR_W-3:0] addr_q;
    logic              wren_q, drop, cnt_done;
    logic [WORD-1:0]   wdata_q, if_rdata_q, ls_rdata_q;
    logic [3:0]        bmask_q;
    logic [CW-1:0]     cnt;
    logic [1:0]        pick;
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^{i_if_addr[1:0], i_ls_addr[1:0]};
    assign cnt_done = cnt == CW'(1);

    rr_arb2 u_rr (
        .if_req   (i_if_req),
        .ls_req   (i_ls_req),
        .last_gnt (last_gnt),
        .gnt      (pick)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_nx;
    end

    // Grants are gated by reset so every output reads 0 while i_rst_n is low.
    always_comb begin
        state_nx    = state;
        o_if_gnt    = state == IDLE && i_rst_n && pick[0];
        o_ls_gnt    = state == IDLE && i_rst_n && pick[1];
        o_mem_en    = state == ACCESS;
        o_mem_we    = state == ACCESS && wren_q;
        o_if_rvalid = state == RESP && id_q == REQ_IF && !drop && !i_if_flush;
        o_ls_rvalid = state == RESP && id_q == REQ_LS;
        o_busy      = state != IDLE;
        case (state)
            IDLE:    state_nx = (o_if_gnt || o_ls_gnt) ? ACCESS : IDLE;
            ACCESS:  state_nx = WAIT;
            WAIT:    state_nx = cnt_done ? RESP : WAIT;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_gnt   <= REQ_IF;
            id_q       <= REQ_IF;
            addr_q     <= '0;
            wren_q     <= 1'b0;
            wdata_q    <= '0;
            bmask_q    <= '0;
            drop       <= 1'b0;
            cnt        <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            if (o_if_gnt || o_ls_gnt) begin
                last_gnt <= o_ls_gnt ? REQ_LS : REQ_IF;
                id_q     <= o_ls_gnt ? REQ_LS : REQ_IF;
                addr_q   <= o_ls_gnt ? i_ls_addr[ADDR_W-1:2] : i_if_addr[ADDR_W-1:2];
                wren_q   <= o_ls_gnt && i_ls_wren;
                wdata_q  <= o_ls_gnt ? i_ls_wdata : '0;
                bmask_q  <= o_ls_gnt ? i_ls_bmask : 4'hF;
                drop     <= o_if_gnt && i_if_flush;
            end else if (state != IDLE && id_q == REQ_IF && i_if_flush) begin
                drop <= 1'b1;
            end
            cnt <= state == ACCESS ? CW'(MEM_LAT) : state == WAIT ? cnt - 1'b1 : cnt;
            if (state == WAIT && cnt_done) begin
                if (id_q == REQ_LS)              ls_rdata_q <= wren_q ? '0 : i_mem_rdata;
                else if (!drop && !i_if_flush)   if_rdata_q <= i_mem_rdata;
            end
        end
    end

    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;
    assign o_mem_bmask = bmask_q;
    assign o_if_rdata  = if_rdata_q;
    assign o_ls_rdata  = ls_rdata_q;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: checks MEM_LAT=1 and MEM_LAT=3 arbiters against a cycle-numbered transaction model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, clr, sel, hold;
    logic        if_req, if_flush, ls_req, ls_wren;
    logic [15:0] if_addr, ls_addr;
    logic [31:0] ls_wdata;
    logic [3:0]  ls_bmask;
    logic [1:0]  if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;
    logic [31:0] if_rdata [2];
    logic [31:0] ls_rdata [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];
    logic [13:0] mem_addr [2];
    logic [3:0]  mem_bmask [2];

    int          n_tests = 0, n_fail = 0;
    int          lat, cyc, gc;
    bit          have, last_ls, t_ls, t_we, t_drop, g_if, g_ls;
    logic [13:0] t_addr;
    logic [31:0] t_wdata, t_data;
    logic [3:0]  t_bmask;
    logic [31:0] ref_mem [16384];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int w);
        return 32'hDEADBEEF + 32'(w - 4) * 32'h00010203;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] b);
        for (int i = 0; i < 4; i++) if (b[i]) o[i*8 +: 8] = n[i*8 +: 8];
        return o;
    endfunction

    for (genvar k = 0; k < 2; k++) begin : g_dut
        logic [31:0] mem [16384];
        logic [31:0] pipe [3];
        mem_arbiter #(.ADDR_W(16), .MEM_LAT(k == 0 ? 1 : 3)) u_dut (
            .i_clk(clk), .i_rst_n(rst_n),
            .i_if_req(if_req), .i_if_addr(if_addr), .i_if_flush(if_flush),
            .o_if_gnt(if_gnt[k]), .o_if_rvalid(if_rvalid[k]), .o_if_rdata(if_rdata[k]),
            .i_ls_req(ls_req), .i_ls_addr(ls_addr), .i_ls_wren(ls_wren),
            .i_ls_wdata(ls_wdata), .i_ls_bmask(ls_bmask),
            .o_ls_gnt(ls_gnt[k]), .o_ls_rvalid(ls_rvalid[k]), .o_ls_rdata(ls_rdata[k]),
            .o_mem_en(mem_en[k]), .o_mem_we(mem_we[k]), .o_mem_addr(mem_addr[k]),
            .o_mem_wdata(mem_wdata[k]), .o_mem_bmask(mem_bmask[k]),
            .i_mem_rdata(mem_rdata[k]), .o_busy(busy[k])
        );
        // Memory macro model: read data appears exactly MEM_LAT cycles after the command.
        always @(posedge clk) begin
            if (clr) for (int i = 0; i < 16384; i++) mem[i] <= init_word(i);
            else if (mem_en[k] && mem_we[k]) mem[mem_addr[k]] <= merge(mem[mem_addr[k]], mem_wdata[k], mem_bmask[k]);
            pipe[0] <= mem_en[k] ? mem[mem_addr[k]] : 32'h0;
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_rdata[k] = k == 0 ? pipe[0] : pipe[2];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_zero();
        chk("rst_if_gnt", 32'(if_gnt[sel]), 0);
        chk("rst_ls_gnt", 32'(ls_gnt[sel]), 0);
        chk("rst_if_rvalid", 32'(if_rvalid[sel]), 0);
        chk("rst_ls_rvalid", 32'(ls_rvalid[sel]), 0);
        chk("rst_if_rdata", if_rdata[sel], 0);
        chk("rst_ls_rdata", ls_rdata[sel], 0);
        chk("rst_mem_en", 32'(mem_en[sel]), 0);
        chk("rst_mem_we", 32'(mem_we[sel]), 0);
        chk("rst_mem_addr", 32'(mem_addr[sel]), 0);
        chk("rst_mem_wdata", mem_wdata[sel], 0);
        chk("rst_mem_bmask", 32'(mem_bmask[sel]), 0);
        chk("rst_busy", 32'(busy[sel]), 0);
    endtask

    // Entered just after a rising edge with inputs settled; compares one cycle then advances.
    task automatic cycle();
        bit act, rv, en, ie;
        @(negedge clk);
        act  = have && cyc > gc && cyc <= gc + 2 + lat;
        rv   = act && cyc == gc + 2 + lat;
        en   = act && cyc == gc + 1;
        g_if = !act && if_req && (!ls_req || last_ls);
        g_ls = !act && ls_req && (!if_req || !last_ls);
        ie   = rv && !t_ls && !t_drop && !if_flush;
        chk("if_gnt", 32'(if_gnt[sel]), 32'(g_if));
        chk("ls_gnt", 32'(ls_gnt[sel]), 32'(g_ls));
        chk("busy", 32'(busy[sel]), 32'(act));
        chk("mem_en", 32'(mem_en[sel]), 32'(en));
        chk("mem_we", 32'(mem_we[sel]), 32'(en && t_we));
        chk("if_rvalid", 32'(if_rvalid[sel]), 32'(ie));
        chk("ls_rvalid", 32'(ls_rvalid[sel]), 32'(rv && t_ls));
        if (en) chk("mem_addr", 32'(mem_addr[sel]), 32'(t_addr));
        if (en && t_we) begin
            chk("mem_wdata", mem_wdata[sel], t_wdata);
            chk("mem_bmask", 32'(mem_bmask[sel]), 32'(t_bmask));
        end
        if (ie) chk("if_rdata", if_rdata[sel], t_data);
        if (rv && t_ls) chk("ls_rdata", ls_rdata[sel], t_data);
        if (act && !t_ls && if_flush) t_drop = 1;
        if (g_if || g_ls) begin
            have    = 1;
            gc      = cyc;
            t_ls    = g_ls;
            last_ls = g_ls;
            t_addr  = g_ls ? ls_addr[15:2] : if_addr[15:2];
            t_we    = g_ls && ls_wren;
            t_wdata = ls_wdata;
            t_bmask = ls_bmask;
            t_drop  = g_if && if_flush;
            t_data  = t_we ? 32'h0 : ref_mem[t_addr];
            if (t_we) ref_mem[t_addr] = merge(ref_mem[t_addr], ls_wdata, ls_bmask);
        end
        cyc++;
        @(posedge clk);
        #1;
        if (!hold) begin
            if (g_if) if_req = 0;
            if (g_ls) ls_req = 0;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 12 && have && cyc <= gc + 2 + lat; i++) cycle();
    endtask

    task automatic ref_init();
        for (int i = 0; i < 16384; i++) ref_mem[i] = init_word(i);
    endtask

    task automatic tie(input int n);
        hold = 1; if_req = 1; ls_req = 1;
        if_addr = 16'h0104; ls_addr = 16'h0208; ls_wren = 0;
        repeat (n * (lat + 3)) cycle();
        hold = 0; if_req = 0; ls_req = 0;
        drain();
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            if (!if_req && $urandom_range(3) == 0) begin
                if_req = 1; if_addr = 16'($urandom_range(15) * 4 + $urandom_range(3));
            end else if (if_req && $urandom_range(15) == 0) if_req = 0;
            if (!ls_req && $urandom_range(2) == 0) begin
                ls_req = 1; ls_addr = 16'($urandom_range(15) * 4 + $urandom_range(3));
                ls_wren = $urandom_range(1) == 1; ls_wdata = $urandom; ls_bmask = 4'($urandom);
            end else if (ls_req && $urandom_range(15) == 0) ls_req = 0;
            if_flush = $urandom_range(7) == 0;
            cycle();
        end
        if_req = 0; ls_req = 0; if_flush = 0;
        drain();
    endtask

    task automatic start_phase(input logic s, input int l);
        sel = s; lat = l; hold = 0;
        if_req = 0; ls_req = 0; if_flush = 0; ls_wren = 0;
        if_addr = 0; ls_addr = 0; ls_wdata = 0; ls_bmask = 0;
        rst_n = 1; clr = 1;
        #2 rst_n = 0;
        ref_init();
        repeat (2) @(posedge clk);
        #1 chk_zero();
        clr = 0; rst_n = 1; have = 0; last_ls = 0; cyc = 0;
    endtask

    initial begin
        start_phase(1'b0, 1);
        // single load at byte 0x0010
        ls_req = 1; ls_addr = 16'h0010; ls_wren = 0;
        cycle(); drain();
        tie(4);
        // store halfword then read it back
        ls_req = 1; ls_addr = 16'h0020; ls_wren = 1; ls_wdata = 32'h12345678; ls_bmask = 4'b0011;
        cycle(); drain();
        ls_req = 1; ls_wren = 0;
        cycle(); drain();
        // flush pulsed in WAIT, then a clean fetch
        if_req = 1; if_addr = 16'h0040;
        cycle(); cycle();
        if_flush = 1; cycle(); if_flush = 0;
        drain();
        if_req = 1; if_addr = 16'h0044;
        cycle(); drain();
        rand_cycles(300);
        // reset while a load sits in WAIT, requests held through reset
        ls_req = 1; ls_addr = 16'h0030; ls_wren = 0;
        cycle(); cycle();
        hold = 1; if_req = 1; ls_req = 1;
        #1 rst_n = 0;
        #1 chk_zero();
        @(posedge clk);
        #1 rst_n = 1; have = 0; last_ls = 0; cyc++;
        repeat (2 * (lat + 3)) cycle();
        hold = 0; if_req = 0; ls_req = 0;
        drain();
        start_phase(1'b1, 3);
        ls_req = 1; ls_addr = 16'h0010; ls_wren = 0;
        cycle(); drain();
        tie(4);
        rand_cycles(200);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
